// File: rtl/ff_resp_checker.sv
// Response checker for a flip-flop DUT: delays d_in by LATENCY clocks, compares the result with
// dut_q over NUM_SAMPLES cycles and reports a verdict. Optional macro: FF_CHECK_STOP_ON_ERR_EN.
module ff_resp_checker #(
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             d_in,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err
);

    typedef enum logic [1:0] {StIdle, StArm, StCheck, StDone} state_e;

    state_e             state_q, state_d;
    logic [LATENCY-1:0] pipe_q, pipe_d;
    logic [3:0]         arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0]   sample_idx_q, sample_idx_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   first_err_q, first_err_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic               run_start, mismatch, last_sample, arm_last;

    assign run_start   = start && ((state_q == StIdle) || (state_q == StDone));
    assign mismatch    = (state_q == StCheck) && (dut_q != pipe_q[LATENCY-1]);
    assign last_sample = (sample_idx_q == CNT_W'(NUM_SAMPLES - 1));
    assign arm_last    = (arm_cnt_q == 4'(LATENCY - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StArm;
            StArm:          if (arm_last) state_d = StCheck;
            StCheck: begin
                if (last_sample) state_d = StDone;
`ifdef FF_CHECK_STOP_ON_ERR_EN
                if (mismatch) state_d = StDone;
`endif
            end
            default:        state_d = StIdle;
        endcase
    end

    // Outputs are registered decodes of the current state, so they trail the state by one clock.
    always_comb begin
        busy_d = (state_q == StArm) || (state_q == StCheck);
        done_d = (state_q == StDone);
        pass_d = done_d && (err_cnt_q == '0);
    end

    always_comb begin
        pipe_d[0] = d_in;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        arm_cnt_d = (state_q == StArm) ? arm_cnt_q + 4'd1 : 4'd0;

        sample_idx_d = sample_idx_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;
        if (run_start) begin
            sample_idx_d = '0;
            err_cnt_d    = '0;
            first_err_d  = '1;
        end else if (state_q == StCheck) begin
            sample_idx_d = sample_idx_q + 1'b1;
            if (mismatch) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                // All-ones means no mismatch recorded yet in this run.
                if (first_err_q == '1) first_err_d = sample_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_q       <= '0;
            arm_cnt_q    <= '0;
            sample_idx_q <= '0;
            err_cnt_q    <= '0;
            first_err_q  <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            pipe_q       <= pipe_d;
            arm_cnt_q    <= arm_cnt_d;
            sample_idx_q <= sample_idx_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

endmodule

// File: tb/tb_ff_resp_checker.sv
// Bench for ff_resp_checker: two checkers (LATENCY 1 and 3) fed the same stimulus, a per-cycle
// behavioural model, and a few literal expectations for the documented scenarios.
module tb_ff_resp_checker;

    localparam int N = 16;
    localparam int Lat[2] = '{1, 3};
`ifdef FF_CHECK_STOP_ON_ERR_EN
    localparam bit Stop = 1'b1;
`else
    localparam bit Stop = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, d_in = 1'b0;
    logic [1:0]  q;
    logic [1:0]  busy, done, pass;
    logic [15:0] err_cnt [2];
    logic [15:0] first_err [2];

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [7:0] dsh = '0;
    int dly[2] = '{1, 3};
    int inv_abs[2] = '{-1, -1};
    bit stuck = 1'b0;
    int rise[2];

    always #5 clk = ~clk;

    ff_resp_checker #(.LATENCY(1), .NUM_SAMPLES(N), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .d_in(d_in), .dut_q(q[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err_cnt[0]), .first_err(first_err[0])
    );

    ff_resp_checker #(.LATENCY(3), .NUM_SAMPLES(N), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .d_in(d_in), .dut_q(q[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err_cnt[1]), .first_err(first_err[1])
    );

    // Emulated DUTs: d_in delayed by dly[j] clocks, optionally stuck low or inverted on one edge.
    always @(posedge clk) dsh <= {dsh[6:0], d_in};
    always_comb begin
        q = '0;
        for (int j = 0; j < 2; j++) begin
            q[j] = stuck ? 1'b0 : (dsh[dly[j]-1] ^ (cyc == inv_abs[j]));
        end
    end

    task automatic check(input string name, input int j, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h at edge %0d", name, j, act, exp, cyc);
        end
    endtask

    // Behavioural model: run mode per checker, with sample i of a run started at edge t0 being
    // d_in at edge t0+1+i compared against dut_q at edge t0+L+1+i.
    int          mmode[2] = '{0, 0};  // 0 idle, 1 running, 2 finished
    int          mt0[2];
    int          mcnt[2] = '{0, 0};
    logic [15:0] mfirst[2] = '{16'hFFFF, 16'hFFFF};
    bit          eb[2], ed[2], ep[2];
    bit          dh[$];
    bit          chk_on = 1'b0;

    always @(posedge clk) begin
        int e, k, i, pm, pc;
        bit mism;
        e = cyc;
        cyc <= cyc + 1;
        dh.push_back(d_in);
        if (dh.size() > 16) void'(dh.pop_front());
        if (!reset) chk_on = 1'b1;
        for (int j = 0; j < 2; j++) begin
            pm = mmode[j];
            pc = mcnt[j];
            if (!reset) begin
                mmode[j] = 0; mcnt[j] = 0; mfirst[j] = 16'hFFFF;
                eb[j] = 1'b0; ed[j] = 1'b0; ep[j] = 1'b0;
            end else begin
                eb[j] = (pm == 1);
                ed[j] = (pm == 2);
                ep[j] = (pm == 2) && (pc == 0);
                if (mmode[j] != 1 && start) begin
                    mmode[j] = 1; mt0[j] = e; mcnt[j] = 0; mfirst[j] = 16'hFFFF;
                end else if (mmode[j] == 1) begin
                    k = e - mt0[j];
                    if (k >= Lat[j] + 1) begin
                        i = k - Lat[j] - 1;
                        mism = (q[j] != dh[dh.size() - 1 - Lat[j]]);
                        if (mism) begin
                            if (mcnt[j] < 65535) mcnt[j]++;
                            if (mfirst[j] == 16'hFFFF) mfirst[j] = 16'(i);
                        end
                        if (i == N - 1 || (Stop && mism)) mmode[j] = 2;
                    end
                end
            end
        end
        #1;
        if (chk_on) begin
            for (int j = 0; j < 2; j++) begin
                check("busy", j, 32'(busy[j]), 32'(eb[j]));
                check("done", j, 32'(done[j]), 32'(ed[j]));
                check("pass", j, 32'(pass[j]), 32'(ep[j]));
                check("err_cnt", j, 32'(err_cnt[j]), 32'(mcnt[j]));
                check("first_err", j, 32'(first_err[j]), 32'(mfirst[j]));
            end
        end
    end

    function automatic logic gen(input int pat, input int k);
        case (pat)
            0:       return logic'(k % 2);
            1:       return logic'($urandom_range(0, 1));
            2:       return 1'b1;
            default: return logic'((k / 2) % 2);
        endcase
    endfunction

    // One run on both checkers; rise[j] = clocks from the start edge until done rises.
    task automatic run(input int pat, input int inj, input bit stk, input int d0, input int d1,
                       input bit spur);
        int ts;
        bit low[2];
        low = '{1'b0, 1'b0};
        rise = '{-1, -1};
        dly[0] = d0; dly[1] = d1; stuck = stk;
        @(negedge clk);
        start = 1'b1; d_in = gen(pat, 0); ts = cyc;
        for (int j = 0; j < 2; j++) inv_abs[j] = (inj < 0) ? -1 : ts + Lat[j] + 1 + inj;
        for (int k = 1; k < 100 && (rise[0] < 0 || rise[1] < 0); k++) begin
            @(negedge clk);
            start = spur && (k == 1);
            d_in = gen(pat, k);
            for (int j = 0; j < 2; j++) begin
                if (!done[j]) low[j] = 1'b1;
                else if (low[j] && rise[j] < 0) rise[j] = cyc - ts - 1;
            end
        end
        start = 1'b0;
        for (int j = 0; j < 2; j++) if (rise[j] < 0) check("run_timeout", j, 32'd0, 32'd1);
        inv_abs = '{-1, -1};
        stuck = 1'b0;
        dly = '{1, 3};
    endtask

    initial begin
        int ts;
        // Reset held for two clocks.
        repeat (2) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check("rst_busy", j, 32'(busy[j]), 32'd0);
            check("rst_done", j, 32'(done[j]), 32'd0);
            check("rst_err", j, 32'(err_cnt[j]), 32'd0);
            check("rst_first", j, 32'(first_err[j]), 32'hFFFF);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Clean alternating run.
        run(0, -1, 1'b0, 1, 3, 1'b0);
        check("clean_lat", 0, 32'(rise[0]), 32'd18);
        check("clean_lat", 1, 32'(rise[1]), 32'd20);
        for (int j = 0; j < 2; j++) begin
            check("clean_pass", j, 32'(pass[j]), 32'd1);
            check("clean_err", j, 32'(err_cnt[j]), 32'd0);
        end

        // Single inverted sample 5.
        run(1, 5, 1'b0, 1, 3, 1'b0);
        for (int j = 0; j < 2; j++) begin
            check("inj_err", j, 32'(err_cnt[j]), 32'd1);
            check("inj_first", j, 32'(first_err[j]), 32'd5);
            check("inj_pass", j, 32'(pass[j]), 32'd0);
        end

        // Stuck-low DUT with d_in high.
        run(2, -1, 1'b1, 1, 3, 1'b0);
        check("stuck_err", 0, 32'(err_cnt[0]), Stop ? 32'd1 : 32'd16);
        check("stuck_first", 0, 32'(first_err[0]), 32'd0);
        if (Stop) check("stuck_lat", 0, 32'(rise[0]), 32'd3);

        // LATENCY=3 checker against a 1-clock DUT.
        run(3, -1, 1'b0, 1, 1, 1'b0);
        check("lat_mis_pass", 1, 32'(pass[1]), 32'd0);
        check("lat_mis_errnz", 1, 32'(err_cnt[1] != 0), 32'd1);
        check("lat_ok_pass", 0, 32'(pass[0]), 32'd1);

        // Reset at sample 7 of the LATENCY=1 checker, then a fresh run.
        @(negedge clk);
        start = 1'b1; d_in = gen(1, 0); ts = cyc;
        for (int k = 0; k < 20 && cyc < ts + 1 + 1 + 7; k++) begin
            @(negedge clk);
            start = 1'b0; d_in = gen(1, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            check("mid_rst_busy", j, 32'(busy[j]), 32'd0);
            check("mid_rst_err", j, 32'(err_cnt[j]), 32'd0);
            check("mid_rst_first", j, 32'(first_err[j]), 32'hFFFF);
        end
        run(1, -1, 1'b0, 1, 3, 1'b0);
        for (int j = 0; j < 2; j++) check("after_rst_pass", j, 32'(pass[j]), 32'd1);

        // Randomized runs: random data, injections, delays and ignored starts.
        for (int r = 0; r < 8; r++) begin
            run(1, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, N - 1)),
                ($urandom_range(0, 5) == 0), int'($urandom_range(1, 2)),
                int'($urandom_range(2, 4)), ($urandom_range(0, 1) == 1));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
